// File: rtl/fp32_pkg.sv
// Shared fp32 field widths, constants and divider state encoding.
// Imported by the divider and reusable by the fp32 multiplier.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } div_state_e;

endpackage

// File: rtl/fp_div32_iter_if.sv
// Operand/result handshake bundle for fp_div32_iter.
// FP_DIV32_FLAGS_EN adds the 5-bit exception flags output.
interface fp_div32_iter_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;
`ifdef FP_DIV32_FLAGS_EN
    logic [4:0]  flags;
`endif

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q
`ifdef FP_DIV32_FLAGS_EN
        , input flags
`endif
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q
`ifdef FP_DIV32_FLAGS_EN
        , output flags
`endif
    );

endinterface

// File: rtl/fp32_classify.sv
// Combinational fp32 operand decode; denormals are reported as zero.
// The sign bit is not needed here, so only the magnitude is taken.
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [30:0] mag_i,
    output logic        is_zero_o,
    output logic        is_inf_o,
    output logic        is_nan_o,
    output logic        hidden_o
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;

    assign exp_f     = mag_i[30:23];
    assign frac_f    = mag_i[22:0];
    assign hidden_o  = |exp_f;
    assign is_zero_o = ~hidden_o;
    assign is_inf_o  = (exp_f == EXP_MAX) && (frac_f == '0);
    assign is_nan_o  = (exp_f == EXP_MAX) && (frac_f != '0);

endmodule

// File: rtl/fp_div32_iter.sv
// Iterative fp32 divider: restoring division, one quotient bit per cycle, RNE.
// Define FP_DIV32_FLAGS_EN to add the {invalid,divbyzero,overflow,underflow,inexact} flags.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// DIV   | one restoring-division step per cycle, QBITS cycles
// ROUND | normalize, round to nearest even, range check
// DONE  | out_valid high, q held until out_ready
module fp_div32_iter
    import fp32_pkg::*;
#(
    parameter int QBITS = 26
) (
    input logic             clk,
    input logic             rst,
    fp_div32_iter_if.slave  bus
);

    div_state_e        state_q;
    logic [4:0]        cnt_q;
    logic              sign_q;
    logic [EXP_W-1:0]  ea_q;
    logic [EXP_W-1:0]  eb_q;
    logic [QBITS-1:0]  rem_q;
    logic [QBITS-1:0]  quo_q;
    logic [23:0]       mb_q;
    logic [31:0]       q_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic a_zero, a_inf, a_nan, a_hidden;
    logic b_zero, b_inf, b_nan, b_hidden;

    fp32_classify u_cls_a (
        .mag_i     (bus.a[30:0]),
        .is_zero_o (a_zero),
        .is_inf_o  (a_inf),
        .is_nan_o  (a_nan),
        .hidden_o  (a_hidden)
    );

    fp32_classify u_cls_b (
        .mag_i     (bus.b[30:0]),
        .is_zero_o (b_zero),
        .is_inf_o  (b_inf),
        .is_nan_o  (b_nan),
        .hidden_o  (b_hidden)
    );

    logic        sign_in;
    logic        spec_hit;
    logic [31:0] spec_res;
`ifdef FP_DIV32_FLAGS_EN
    logic        spec_inv;
    logic        spec_dbz;
`endif

    // Special-case decode in priority order; 0/0 is caught before x/0.
    always_comb begin
        sign_in  = bus.a[31] ^ bus.b[31];
        spec_hit = 1'b1;
        spec_res = '0;
`ifdef FP_DIV32_FLAGS_EN
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
`endif
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = QNAN;
`ifdef FP_DIV32_FLAGS_EN
            spec_inv = 1'b1;
`endif
        end else if (a_inf || b_zero) begin
            spec_res = {sign_in, EXP_MAX, {FRAC_W{1'b0}}};
`ifdef FP_DIV32_FLAGS_EN
            spec_dbz = ~a_inf;
`endif
        end else if (a_zero || b_inf) begin
            spec_res = {sign_in, 31'h0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic [QBITS-1:0] diff;
    logic             qbit;
    logic [QBITS-1:0] rem_d;
    logic [QBITS-1:0] quo_d;

    always_comb begin
        diff  = rem_q - {2'b00, mb_q};
        qbit  = (rem_q >= {2'b00, mb_q});
        rem_d = (qbit ? diff : rem_q) << 1;
        quo_d = {quo_q[QBITS-2:0], qbit};
    end

    logic              norm;
    logic [FRAC_W-1:0] frac_sel;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic              carry;
    logic [FRAC_W-1:0] frac_r;
    logic signed [9:0] exp_r;
    logic              unf;
    logic              ovf;
    logic              inexact;
    logic [31:0]       res_d;

    // The hidden bit is implicit: quotient lies in (0.5, 2), so the leading
    // kept bit is always 1 and only the fraction needs rounding.
    always_comb begin
        norm = quo_q[25];
        if (norm) begin
            frac_sel = quo_q[24:2];
            guard    = quo_q[1];
            sticky   = quo_q[0] | (rem_q != '0);
        end else begin
            frac_sel = quo_q[23:1];
            guard    = quo_q[0];
            sticky   = (rem_q != '0);
        end
        round_up        = guard & (sticky | frac_sel[0]);
        {carry, frac_r} = {1'b0, frac_sel} + {{FRAC_W{1'b0}}, round_up};
        exp_r = {2'b00, ea_q} - {2'b00, eb_q} + 10'(BIAS)
              - {9'd0, ~norm} + {9'd0, carry};
        unf     = (exp_r <= 10'sd0);
        ovf     = (exp_r >= 10'sd255);
        inexact = guard | sticky | unf | ovf;
        if (unf) begin
            res_d = {sign_q, 31'h0};
        end else if (ovf) begin
            res_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
        end else begin
            res_d = {sign_q, exp_r[7:0], frac_r};
        end
    end

`ifdef FP_DIV32_FLAGS_EN
    logic [4:0] flags_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            mb_q        <= '0;
            q_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef FP_DIV32_FLAGS_EN
            flags_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        sign_q     <= sign_in;
                        ea_q       <= bus.a[30:23];
                        eb_q       <= bus.b[30:23];
                        rem_q      <= {2'b00, a_hidden, bus.a[22:0]};
                        mb_q       <= {b_hidden, bus.b[22:0]};
                        quo_q      <= '0;
                        in_ready_q <= 1'b0;
`ifdef FP_DIV32_FLAGS_EN
                        flags_q    <= '0;
`endif
                        if (spec_hit) begin
                            q_q         <= spec_res;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
`ifdef FP_DIV32_FLAGS_EN
                            flags_q     <= {spec_inv, spec_dbz, 3'b000};
`endif
                        end else begin
                            cnt_q   <= 5'(QBITS - 1);
                            state_q <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        state_q <= ROUND;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                ROUND: begin
                    q_q         <= res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
`ifdef FP_DIV32_FLAGS_EN
                    flags_q     <= {2'b00, ovf, unf, inexact};
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.q         = q_q;
`ifdef FP_DIV32_FLAGS_EN
    assign bus.flags     = flags_q;
`endif

endmodule

// File: tb/tb_fp_div32_iter.sv
// Self-checking bench for fp_div32_iter: directed plan plus random operands
// compared against an integer-division reference model.
module tb_fp_div32_iter;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fp_div32_iter_if bus ();

    fp_div32_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: quotient = floor(ma * 2^25 / mb), then normalize and round.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            output int lat);
        logic   s;
        int     ea, eb, e;
        bit     a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
        longint ma, mb, num, quo, r, mant;
        bit     guard, sticky;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        lat    = 1;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC00000;
        if (a_inf || b_zero) return {s, 8'hFF, 23'h0};
        if (a_zero || b_inf) return {s, 31'h0};
        lat  = 28;
        ma   = 64'h800000 + longint'(a[22:0]);
        mb   = 64'h800000 + longint'(b[22:0]);
        num  = ma * 64'd33554432;
        quo  = num / mb;
        r    = num % mb;
        e    = ea - eb + 127;
        if (quo >= 64'd33554432) begin
            mant   = quo / 4;
            guard  = quo[1];
            sticky = quo[0] || (r != 0);
        end else begin
            mant   = quo / 2;
            guard  = quo[0];
            sticky = (r != 0);
            e      = e - 1;
        end
        if (guard && (sticky || mant[0])) mant = mant + 1;
        if (mant == 64'd16777216) begin
            mant = 64'd8388608;
            e    = e + 1;
        end
        if (e <= 0) return {s, 31'h0};
        if (e >= 255) return {s, 8'hFF, 23'h0};
        return {s, e[7:0], mant[22:0]};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit rdy_seen);
        lat      = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.in_ready) rdy_seen = 1'b1;
        end while (!bus.out_valid && lat < 64);
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input int exp_lat, input string tag);
        int lat;
        bit rdy_seen;
        send(a, b);
        wait_out(lat, rdy_seen);
        check({tag, "_q"}, bus.q, exp_q);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, {31'h0, rdy_seen}, 32'h0);
        take();
    endtask

    initial begin
        int          lat, mlat;
        bit          rdy_seen;
        logic [31:0] ra, rb, mq;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_q", bus.q, 32'h0);

        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 28, "div_6_2");
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, "div_1_3");
        run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 28, "div_1_1");

        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1, "sp_x_0");
        run_op(32'hBF800000, 32'h00000000, 32'hFF800000, 1, "sp_negx_0");
        run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 1, "sp_0_0");
        run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1, "sp_inf_inf");
        run_op(32'h40000000, 32'h7F800000, 32'h00000000, 1, "sp_x_inf");

        run_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 28, "ovf");
        run_op(32'h00800000, 32'h40000000, 32'h00000000, 28, "unf_pos");
        run_op(32'h80800000, 32'h40000000, 32'h80000000, 28, "unf_neg");

        // Backpressure: result held, no capture of a pending request.
        send(32'h40C00000, 32'h40000000);
        wait_out(lat, rdy_seen);
        check("bp_lat", 32'(lat), 32'd28);
        bus.a        = 32'h3F800000;
        bus.b        = 32'h3F800000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_q", bus.q, 32'h40400000);
            check("bp_in_ready", {31'h0, bus.in_ready}, 32'h0);
            check("bp_out_valid", {31'h0, bus.out_valid}, 32'h1);
        end
        bus.in_valid = 1'b0;
        take();
        @(negedge clk);
        check("bp_release_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("bp_release_out_valid", {31'h0, bus.out_valid}, 32'h0);

        // Reset in the middle of a division.
        send(32'h40C00000, 32'h40000000);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("mid_rst_q", bus.q, 32'h0);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 28, "post_rst_6_2");

        for (int i = 0; i < 70; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i >= 20) begin
                ra[30:23] = 8'(96 + $urandom_range(0, 63));
                rb[30:23] = 8'(96 + $urandom_range(0, 63));
            end
            if (i % 10 == 3) rb[30:23] = 8'h00;
            if (i % 10 == 7) ra[30:23] = 8'hFF;
            if (i % 17 == 5) ra[22:0] = 23'h0;
            mq = ref_div(ra, rb, mlat);
            run_op(ra, rb, mq, mlat, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
